// File: rtl/stage_sequencer.sv
// Clocked stage sequencer for the multi-cycle RV32I datapath: walks the fetch/decode/execute/
// memory/writeback units through 4-phase req/ack handshakes, with the stage list chosen by opcode.
module stage_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic       ack1,
  input  logic       ack2_1,
  input  logic       ack2_2,
  input  logic       ack3,
  input  logic       ack4,
  output logic       req1,
  output logic       req2_1,
  output logic       req2_2,
  output logic       req3,
  output logic       req4,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo, StFinish} state_e;
  typedef enum logic [2:0] {StgF, StgD, StgE, StgM, StgW} stage_e;
  typedef enum logic [2:0] {ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsIllegal} cls_e;

  state_e          state_q, state_d;
  stage_e          stage_q, stage_d, nxt_stage;
  logic [6:0]      opcode_q, opcode_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [4:0]      req_q, req_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            illegal_q, illegal_d, timeout_q, timeout_d;

  logic [4:0] ack_vec;
  logic       cur_ack, nxt_last, wd_hit;
  cls_e       cls;

  assign ack_vec = {ack4, ack3, ack2_2, ack2_1, ack1};
  assign wd_hit  = (cnt_q == TO_W'(TIMEOUT));

  always_comb begin
    cur_ack = 1'b0;
    case (stage_q)
      StgF:    cur_ack = ack_vec[0];
      StgD:    cur_ack = ack_vec[1];
      StgE:    cur_ack = ack_vec[2];
      StgM:    cur_ack = ack_vec[3];
      StgW:    cur_ack = ack_vec[4];
      default: cur_ack = 1'b0;
    endcase
  end

  always_comb begin
    cls = ClsIllegal;
    case (opcode_q)
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: cls = ClsAlu;
      7'b0000011:                         cls = ClsLoad;
      7'b0100011:                         cls = ClsStore;
      7'b1100011:                         cls = ClsBranch;
      default:                            cls = ClsIllegal;
    endcase
  end

  // Successor of the current stage for the captured instruction class, or end of list.
  always_comb begin
    nxt_stage = stage_q;
    nxt_last  = 1'b0;
    case (stage_q)
      StgF: nxt_stage = StgD;
      StgD: begin
        if (cls == ClsIllegal) nxt_last = 1'b1;
        else                   nxt_stage = StgE;
      end
      StgE: begin
        case (cls)
          ClsAlu:             nxt_stage = StgW;
          ClsLoad, ClsStore:  nxt_stage = StgM;
          default:            nxt_last  = 1'b1;
        endcase
      end
      StgM: begin
        if (cls == ClsLoad) nxt_stage = StgW;
        else                nxt_last  = 1'b1;
      end
      default: nxt_last = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    opcode_d  = opcode_q;
    timeout_d = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (ack_vec == 5'b0)) begin
          state_d = StReqHi;
          stage_d = StgF;
        end
      end
      StReqHi: begin
        if (wd_hit) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else if (cur_ack) begin
          state_d = StReqLo;
          if (stage_q == StgD) opcode_d = opcode;
        end
      end
      StReqLo: begin
        if (wd_hit) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else if (!cur_ack) begin
          if (nxt_last) begin
            state_d   = StFinish;
            illegal_d = (cls == ClsIllegal);
          end else begin
            state_d = StReqHi;
            stage_d = nxt_stage;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Watchdog restarts on every state entry.
    if ((state_d != state_q) || !((state_q == StReqHi) || (state_q == StReqLo))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    req_d  = (state_d == StReqHi) ? (5'b00001 << stage_d) : 5'b0;
    busy_d = (state_d == StReqHi) || (state_d == StReqLo);
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      stage_q   <= StgF;
      opcode_q  <= '0;
      cnt_q     <= '0;
      req_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign {req4, req3, req2_2, req2_1, req1} = req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: expected req-rise/end events are queued at start and
// consumed as the monitor observes them; a behavioural ack responder closes each handshake.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [6:0] opcode;
  logic       ack1, ack2_1, ack2_2, ack3, ack4;
  logic       req1, req2_1, req2_2, req3, req4;
  logic       busy, done, illegal, timeout;

  always #5 clk = ~clk;

  stage_sequencer #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .ack1   (ack1),
    .ack2_1 (ack2_1),
    .ack2_2 (ack2_2),
    .ack3   (ack3),
    .ack4   (ack4),
    .req1   (req1),
    .req2_1 (req2_1),
    .req2_2 (req2_2),
    .req3   (req3),
    .req4   (req4),
    .busy   (busy),
    .done   (done),
    .illegal(illegal),
    .timeout(timeout)
  );

  // Responder: zero-latency (ack follows req combinationally) or one cycle behind req.
  logic [4:0] req_vec, ack_vec, ack_dly, ack_mask;
  logic       zero_lat;
  assign req_vec = {req4, req3, req2_2, req2_1, req1};
  always @(posedge clk) ack_dly <= req_vec;
  assign ack_vec = (zero_lat ? req_vec : ack_dly) & ~ack_mask;
  assign {ack4, ack3, ack2_2, ack2_1, ack1} = ack_vec;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event codes: 0..4 stage req rises (F,D,E,M,W), 8 done, 9 done+illegal, 10 timeout,
  // 11 stray illegal, 99 nothing expected.
  int         exp_q[$];
  int         end_cnt = 0;
  int         rise_cyc[5];
  int         done_cyc, timeout_cyc, start_cyc;
  logic [4:0] seen_mask, prev_req;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic observe(input int code);
    int e;
    if (exp_q.size() == 0) e = 99;
    else                   e = exp_q.pop_front();
    check_eq("sb_event", code, e);
  endtask

  initial begin : monitor
    prev_req  = '0;
    seen_mask = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_eq("req_onehot", ($countones(req_vec) <= 1), 1);
        for (int s = 0; s < 5; s++) begin
          if (req_vec[s] && !prev_req[s]) begin
            rise_cyc[s] = cyc;
            observe(s);
          end
        end
        seen_mask = seen_mask | req_vec;
        if (done) begin
          check_eq("busy_at_done", busy, 0);
          observe(illegal ? 9 : 8);
          done_cyc = cyc;
          end_cnt++;
        end else if (illegal) begin
          observe(11);
        end
        if (timeout) begin
          check_eq("req_at_timeout", req_vec, 0);
          check_eq("busy_at_timeout", busy, 0);
          observe(10);
          timeout_cyc = cyc;
          end_cnt++;
        end
      end
      prev_req = req_vec;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: begin
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(4); exp_q.push_back(8);
      end
      7'b0000011: begin
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(8);
      end
      7'b0100011: begin
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(8);
      end
      7'b1100011: begin
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(8);
      end
      default: begin
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(9);
      end
    endcase
  endtask

  task automatic begin_seq(input logic [6:0] op, input logic zl, input logic hold);
    step();
    opcode    = op;
    zero_lat  = zl;
    seen_mask = '0;
    start     = 1'b1;
    start_cyc = cyc;
    if (!hold) begin
      step();
      start = 1'b0;
    end
  endtask

  task automatic wait_end(input int bound);
    int e0;
    e0 = end_cnt;
    for (int i = 0; i < bound && end_cnt == e0; i++) step();
    check_eq("end_reached", (end_cnt != e0), 1);
  endtask

  task automatic drain_check();
    repeat (3) step();
    check_eq("busy_idle", busy, 0);
    check_eq("sb_drained", exp_q.size(), 0);
  endtask

  initial begin : driver
    reset    = 1'b1;
    start    = 1'b0;
    opcode   = '0;
    zero_lat = 1'b0;
    ack_mask = '0;
    repeat (3) step();
    check_eq("rst_req", req_vec, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_timeout", timeout, 0);
    reset = 1'b0;
    step();

    // R-type, acks one cycle behind each req edge.
    push_exp(7'b0110011);
    begin_seq(7'b0110011, 1'b0, 1'b0);
    wait_end(200);
    check_eq("rtype_mask", seen_mask, 5'b10111);
    drain_check();

    // Load with zero-latency acks: 10 stage cycles plus FINISH.
    push_exp(7'b0000011);
    begin_seq(7'b0000011, 1'b1, 1'b0);
    wait_end(200);
    check_eq("load_mask", seen_mask, 5'b11111);
    check_eq("load_latency", done_cyc - start_cyc, 11);
    drain_check();

    push_exp(7'b0100011);
    begin_seq(7'b0100011, 1'b1, 1'b0);
    wait_end(200);
    check_eq("store_mask", seen_mask, 5'b01111);
    drain_check();

    push_exp(7'b1100011);
    begin_seq(7'b1100011, 1'b0, 1'b0);
    wait_end(200);
    check_eq("branch_mask", seen_mask, 5'b00111);
    drain_check();

    // Store whose opcode turns into a load once decode has been acknowledged.
    push_exp(7'b0100011);
    begin_seq(7'b0100011, 1'b1, 1'b0);
    for (int i = 0; i < 50 && !req_vec[2]; i++) step();
    check_eq("exec_reached", req_vec[2], 1);
    opcode = 7'b0000011;
    wait_end(200);
    check_eq("opchg_mask", seen_mask, 5'b01111);
    drain_check();

    push_exp(7'b1111111);
    begin_seq(7'b1111111, 1'b0, 1'b0);
    wait_end(200);
    check_eq("illegal_mask", seen_mask, 5'b00011);
    drain_check();

    push_exp(7'b1100111);
    begin_seq(7'b1100111, 1'b1, 1'b0);
    wait_end(200);
    check_eq("jalr_mask", seen_mask, 5'b10111);
    drain_check();

    // Reset held two cycles while a load sits in the memory stage.
    push_exp(7'b0000011);
    begin_seq(7'b0000011, 1'b1, 1'b0);
    for (int i = 0; i < 50 && !req_vec[3]; i++) step();
    check_eq("mem_reached", req_vec[3], 1);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("rst_mid_req3", req3, 0);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_done", done, 0);
      check_eq("rst_mid_timeout", timeout, 0);
    end
    reset = 1'b0;
    exp_q.delete();
    step();
    push_exp(7'b0010011);
    begin_seq(7'b0010011, 1'b1, 1'b0);
    wait_end(200);
    check_eq("post_rst_mask", seen_mask, 5'b10111);
    drain_check();

    // Execute unit never acknowledges; start stays high the whole time.
    ack_mask = 5'b00100;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(10);
    begin_seq(7'b0110011, 1'b1, 1'b1);
    wait_end(200);
    start = 1'b0;
    check_eq("wd_latency", timeout_cyc - rise_cyc[2], 5);
    drain_check();
    ack_mask = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_guard
    #200000;
    $display("FAIL global_guard got=running exp=finished");
    $fatal(1);
  end

endmodule
